// File: rtl/hwpe_ctrl_job_launcher.sv
// hwpe_ctrl_job_launcher
// Sequences one accelerator job as n_iter back-to-back engine iterations.
// The FSM walks IDLE -> LAUNCH -> WAIT -> (LAUNCH | DONE) -> IDLE.
// Every output is a flop: each output's next value is decoded from state_d,
// so it lines up with the state register.
//
// Optional feature: define HWPE_CTRL_JOB_TIMEOUT_EN to add a WAIT watchdog.
// The watchdog aborts the job after TIMEOUT_CYCLES WAIT cycles with no
// engine_done_i. It then raises the sticky error_o. Without the macro,
// error_o is tied low and WAIT can last indefinitely.
//
// Handshake: engine_start_o is a single-cycle request. The engine answers
// later with a single-cycle engine_done_i. The block looks at engine_done_i
// only in WAIT and ignores it in every other state.
module hwpe_ctrl_job_launcher #(
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] n_iter_i,
  output logic                 engine_start_o,
  input  logic                 engine_done_i,
  output logic                 done_o,
  output logic                 evt_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] iter_cnt_o,
  output logic                 error_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  // A zero watchdog limit makes no sense, so reject it at elaboration.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] n_q, n_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 evt_q, evt_d;
  logic                 engine_start_q, engine_start_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  // cnt_q is always below n_q while in WAIT, so this increment cannot wrap.
  assign cnt_inc = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

`ifdef HWPE_CTRL_JOB_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`endif

  // Next-state, counters and registered outputs; clear_i overrides everything.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    evt_d   = 1'b0;
`ifdef HWPE_CTRL_JOB_TIMEOUT_EN
    err_d   = err_q;
    wd_d    = '0;
`endif
    if (clear_i) begin
      state_d = IDLE;
      cnt_d   = '0;
`ifdef HWPE_CTRL_JOB_TIMEOUT_EN
      err_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            n_d   = n_iter_i;
            cnt_d = '0;
`ifdef HWPE_CTRL_JOB_TIMEOUT_EN
            err_d = 1'b0;
`endif
            state_d = (n_iter_i == '0) ? DONE : LAUNCH;
          end
        end
        LAUNCH: begin
          // The watchdog restarts from 0 on each WAIT entry (wd_d defaults to 0).
          state_d = WAIT;
        end
        WAIT: begin
          // engine_done_i takes precedence over a watchdog expiry in the same cycle.
          if (engine_done_i) begin
            cnt_d   = cnt_inc;
            evt_d   = 1'b1;
            state_d = (cnt_inc == n_q) ? DONE : LAUNCH;
          end
`ifdef HWPE_CTRL_JOB_TIMEOUT_EN
          else if (wd_q == WD_LAST) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
`endif
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    engine_start_d = (state_d == LAUNCH);
    done_d         = (state_d == DONE);
    busy_d         = (state_d != IDLE);
  end

  // State, latched count, counter and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      n_q            <= '0;
      cnt_q          <= '0;
      evt_q          <= 1'b0;
      engine_start_q <= 1'b0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      cnt_q          <= cnt_d;
      evt_q          <= evt_d;
      engine_start_q <= engine_start_d;
      done_q         <= done_d;
      busy_q         <= busy_d;
    end
  end

`ifdef HWPE_CTRL_JOB_TIMEOUT_EN
  // Watchdog counter and sticky abort flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign error_o = err_q;
`else
  assign error_o = 1'b0;
`endif

  assign engine_start_o = engine_start_q;
  assign done_o         = done_q;
  assign evt_o          = evt_q;
  assign busy_o         = busy_q;
  assign iter_cnt_o     = cnt_q;

endmodule

// File: tb/tb_hwpe_ctrl_job_launcher.sv
// Testbench for hwpe_ctrl_job_launcher.
// A job-level reference model predicts all outputs on every cycle.
// Literal checks at key points pin that model.
module tb_hwpe_ctrl_job_launcher;

  localparam int CW = 4;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          clear_i = 1'b0;
  logic          start_i = 1'b0;
  logic [CW-1:0] n_iter_i = '0;
  logic          engine_start_o;
  logic          engine_done_i;
  logic          done_o, evt_o, busy_o, error_o;
  logic [CW-1:0] iter_cnt_o;

  logic resp_done = 1'b0;
  logic stray_done = 1'b0;
  assign engine_done_i = resp_done | stray_done;

  always #5 clk_i = ~clk_i;

  hwpe_ctrl_job_launcher #(.CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .start_i        (start_i),
    .n_iter_i       (n_iter_i),
    .engine_start_o (engine_start_o),
    .engine_done_i  (engine_done_i),
    .done_o         (done_o),
    .evt_o          (evt_o),
    .busy_o         (busy_o),
    .iter_cnt_o     (iter_cnt_o),
    .error_o        (error_o)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The model tracks the job as "busy / pulse due next cycle".
  // It updates from the inputs seen at each rising edge.
  logic          m_busy = 0, m_start = 0, m_done = 0, m_evt = 0, m_err = 0;
  logic [CW-1:0] m_cnt = '0, m_n = '0;
  int            m_wd = 0;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_busy <= 0; m_start <= 0; m_done <= 0; m_evt <= 0; m_err <= 0;
      m_cnt <= '0; m_n <= '0; m_wd <= 0;
    end else begin
      m_start <= 0; m_done <= 0; m_evt <= 0;
      if (clear_i) begin
        m_busy <= 0; m_cnt <= '0; m_err <= 0;
      end else if (!m_busy) begin
        if (start_i) begin
          m_n <= n_iter_i; m_cnt <= '0; m_err <= 0; m_busy <= 1;
          if (n_iter_i == 0) m_done <= 1; else m_start <= 1;
        end
      end else if (m_start) begin
        m_wd <= 0;
      end else if (m_done) begin
        m_busy <= 0;
      end else if (engine_done_i) begin
        m_cnt <= m_cnt + 1'b1;
        m_evt <= 1;
        if (int'(m_cnt) + 1 == int'(m_n)) m_done <= 1; else m_start <= 1;
      end
`ifdef HWPE_CTRL_JOB_TIMEOUT_EN
      else if (m_wd == TO - 1) begin
        m_done <= 1; m_err <= 1;
      end else begin
        m_wd <= m_wd + 1;
      end
`endif
    end
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  always @(negedge clk_i) begin
    if (rst_ni) begin
      check("engine_start_o", engine_start_o, m_start);
      check("done_o", done_o, m_done);
      check("evt_o", evt_o, m_evt);
      check("busy_o", busy_o, m_busy);
      check("iter_cnt_o", iter_cnt_o, m_cnt);
      check("error_o", error_o, m_err);
    end
  end

  // Pulse counters, used by the literal checks.
  int n_starts = 0, n_evts = 0, n_dones = 0;
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (engine_start_o) n_starts <= n_starts + 1;
      if (evt_o)          n_evts   <= n_evts + 1;
      if (done_o)         n_dones  <= n_dones + 1;
    end
  end

  // ---------------- engine responder ----------------
  logic resp_en = 1'b1;
  logic resp_rand = 1'b0;
  int   resp_delay = 2;
  initial begin
    int pending;
    pending = 0;
    forever begin
      @(negedge clk_i);
      resp_done = 1'b0;
      if (!rst_ni) pending = 0;
      else begin
        if (pending > 0) begin
          pending--;
          if (pending == 0) resp_done = 1'b1;
        end
        if (resp_en && engine_start_o)
          pending = resp_rand ? int'($urandom_range(1, 4)) : resp_delay;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(negedge clk_i); #1; end
  endtask

  task automatic pulse_start(input int n);
    n_iter_i = CW'(n);
    start_i  = 1'b1;
    cyc(1);
    start_i  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (done_o) break;
      cyc(1);
    end
    if (k == budget) check({name, "_done_timeout"}, 0, 1);
  endtask

  task automatic run_job(input string name, input int n);
    int s0, e0, d0;
    s0 = n_starts; e0 = n_evts; d0 = n_dones;
    pulse_start(n);
    wait_done(name, 400);
    cyc(1);
    check({name, "_starts"}, n_starts - s0, n);
    check({name, "_evts"}, n_evts - e0, n);
    check({name, "_dones"}, n_dones - d0, 1);
    check({name, "_cnt"}, iter_cnt_o, n);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int s0, d0, k;
    cyc(3);
    check("rst_busy", busy_o, 0);
    check("rst_cnt", iter_cnt_o, 0);
    check("rst_pulses", {engine_start_o, done_o, evt_o, error_o}, 0);
    rst_ni = 1'b1;
    cyc(2);

    // Three iterations with a 2-cycle engine response.
    resp_delay = 2;
    run_job("n3", 3);

    // Zero-iteration job: done_o one cycle after the start pulse.
    s0 = n_starts;
    pulse_start(0);
    check("n0_done", done_o, 1);
    check("n0_busy", busy_o, 1);
    check("n0_start", engine_start_o, 0);
    cyc(1);
    check("n0_busy_after", busy_o, 0);
    check("n0_evt", n_evts - n_evts, 0);
    check("n0_starts", n_starts - s0, 0);

    // start_i re-pulsed during the job with a different count; the job is unaffected.
    resp_delay = 6;
    s0 = n_starts; d0 = n_dones;
    pulse_start(2);
    cyc(2);
    n_iter_i = 4'd9; start_i = 1'b1;
    cyc(2);
    start_i = 1'b0;
    wait_done("restart", 400);
    cyc(1);
    check("restart_cnt", iter_cnt_o, 2);
    check("restart_starts", n_starts - s0, 2);
    check("restart_dones", n_dones - d0, 1);
    // engine_done_i while idle does nothing.
    cyc(2);
    stray_done = 1'b1;
    cyc(1);
    stray_done = 1'b0;
    cyc(1);
    check("stray_busy", busy_o, 0);
    check("stray_cnt", iter_cnt_o, 2);
    check("stray_evt", evt_o, 0);

    // Clear after the 2nd iteration of a 5-iteration job.
    resp_delay = 2;
    d0 = n_dones;
    pulse_start(5);
    for (k = 0; k < 100 && iter_cnt_o != 2; k++) cyc(1);
    check("clr_reach2", iter_cnt_o, 2);
    clear_i = 1'b1;
    cyc(1);
    clear_i = 1'b0;
    check("clr_busy", busy_o, 0);
    check("clr_cnt", iter_cnt_o, 0);
    check("clr_start", engine_start_o, 0);
    cyc(10);
    check("clr_no_done", n_dones - d0, 0);

    // clear_i together with start_i: the job does not start.
    n_iter_i = 4'd3; start_i = 1'b1; clear_i = 1'b1;
    cyc(1);
    start_i = 1'b0; clear_i = 1'b0;
    check("clr_start_busy", busy_o, 0);
    check("clr_start_es", engine_start_o, 0);
    cyc(2);

    // Asynchronous reset while in WAIT, then a fresh 4-iteration job.
    pulse_start(4);
    for (k = 0; k < 50; k++) begin
      if (busy_o && !engine_start_o && !done_o) break;
      cyc(1);
    end
    d0 = n_dones;
    #2 rst_ni = 1'b0;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_cnt", iter_cnt_o, 0);
    check("arst_pulses", {engine_start_o, done_o, evt_o, error_o}, 0);
    cyc(2);
    rst_ni = 1'b1;
    cyc(3);
    check("arst_no_done", n_dones - d0, 0);
    run_job("fresh4", 4);

    // Full-range count: no wrap of the iteration counter.
    resp_delay = 1;
    run_job("max", (1 << CW) - 1);

`ifdef HWPE_CTRL_JOB_TIMEOUT_EN
    // Engine never answers: the watchdog aborts eight cycles after WAIT entry.
    resp_en = 1'b0;
    pulse_start(2);
    for (k = 1; k <= 9; k++) begin
      cyc(1);
      check($sformatf("to_done_c%0d", k), done_o, (k == 9) ? 1 : 0);
      check($sformatf("to_err_c%0d", k), error_o, (k == 9) ? 1 : 0);
    end
    check("to_cnt", iter_cnt_o, 0);
    cyc(2);
    check("to_err_sticky", error_o, 1);
    resp_en = 1'b1; resp_delay = 2;
    pulse_start(1);
    check("to_err_cleared", error_o, 0);
    wait_done("after_to", 100);
    cyc(2);
`endif

    // Random jobs with random engine latency, stray starts and rare clears.
    resp_rand = 1'b1;
    for (int j = 0; j < 25; j++) begin
      pulse_start(int'($urandom_range(0, 7)));
      for (k = 0; k < 400; k++) begin
        if (done_o || !busy_o) begin
          start_i = 1'b0; clear_i = 1'b0;
          break;
        end
        start_i  = ($urandom_range(0, 4) == 0);
        n_iter_i = CW'($urandom);
        clear_i  = ($urandom_range(0, 60) == 0);
        cyc(1);
      end
      start_i = 1'b0; clear_i = 1'b0;
      check("rand_job_ends", (k < 400) ? 1 : 0, 1);
      cyc(int'($urandom_range(1, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
